ld_queue: RTL and testbench

Non-blocking, parametrised load unit for the Tomasulo back end.
- Buffers up to DEPTH loads, each tagged with its reservation-station number.
- Looks each load up in an external single-port synchronous L1D.
- Sends misses to memory, merging misses to the same address, and matches out-of-order address-tagged memory responses.
- Returns results to the CDB with a valid/ready handshake; supports a pipeline flush.

---
 rtl/ld_queue_pkg.sv | 17 +
 rtl/ld_queue_lowest_set.sv | 22 ++
 rtl/ld_queue.sv | 185 ++++++++++++++++++
 tb/tb_ld_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_queue_pkg.sv
// Shared types for the load queue: per-entry state encoding and the load
// opcodes used by the issue logic.
package ld_queue_pkg;

  typedef enum logic [2:0] {
    ST_FREE     = 3'd0,
    ST_NEW      = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_MISS     = 3'd3,
    ST_INFLIGHT = 3'd4,
    ST_DONE     = 3'd5
  } entry_st_e;

  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_LDR = 4'd5;

endpackage

// File: rtl/ld_queue_lowest_set.sv
// Priority encoder: reports whether any bit of vec is set and the index of
// the lowest set bit (0 when none).
module lowest_set #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/ld_queue.sv
// Non-blocking load queue: allocates loads, looks them up in the L1D, issues
// and merges misses to memory, and returns results to the CDB.
//   state    | meaning
//   FREE     | slot unused
//   NEW      | accepted, waiting for the L1D port
//   LOOKUP   | cache_re issued last cycle, hit/miss resolves this cycle
//   MISS     | missed, waiting for the memory issue slot
//   INFLIGHT | request outstanding (own or merged into an older one)
//   DONE     | data valid, waiting for the CDB
module ld_queue
  import ld_queue_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int TW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req_valid,
  input  logic [TW-1:0] req_tag,
  input  logic [AW-1:0] req_addr,
  output logic          req_ready,
  output logic          cache_re,
  output logic [AW-1:0] cache_addr,
  input  logic          cache_hit,
  input  logic [DW-1:0] cache_data,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic          mem_ready,
  input  logic [AW-1:0] mem_addr_out,
  input  logic [DW-1:0] mem_data_out,
  output logic          valid_out,
  output logic [TW-1:0] tag_out,
  output logic [DW-1:0] res_out,
  input  logic          res_ready,
  output logic          busy
);

  localparam int IW = $clog2(DEPTH);

  entry_st_e     st_q   [DEPTH];
  entry_st_e     st_d   [DEPTH];
  logic [TW-1:0] tag_q  [DEPTH];
  logic [TW-1:0] tag_d  [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          hold_q, hold_d;
  logic [IW-1:0] hold_idx_q, hold_idx_d;

  logic [DEPTH-1:0] free_vec, new_vec, miss_vec, done_vec;
  logic             free_found, new_found, miss_found, done_found;
  logic [IW-1:0]    free_idx, new_idx, miss_idx, done_idx;

  logic          alloc, pop, merge, sel_valid;
  logic [IW-1:0] sel_idx;
  logic [AW-1:0] miss_addr;

  always_comb begin
    free_vec = '0;
    new_vec  = '0;
    miss_vec = '0;
    done_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = (st_q[i] == ST_FREE);
      new_vec[i]  = (st_q[i] == ST_NEW);
      miss_vec[i] = (st_q[i] == ST_MISS);
      done_vec[i] = (st_q[i] == ST_DONE);
    end
  end

  lowest_set #(.N(DEPTH)) u_sel_free (.vec(free_vec), .found(free_found), .idx(free_idx));
  lowest_set #(.N(DEPTH)) u_sel_new  (.vec(new_vec),  .found(new_found),  .idx(new_idx));
  lowest_set #(.N(DEPTH)) u_sel_miss (.vec(miss_vec), .found(miss_found), .idx(miss_idx));
  lowest_set #(.N(DEPTH)) u_sel_done (.vec(done_vec), .found(done_found), .idx(done_idx));

  // A result shown but not taken stays selected, so a lower entry finishing
  // later cannot change the CDB outputs mid-stall.
  always_comb begin
    sel_idx    = hold_q ? hold_idx_q : done_idx;
    sel_valid  = hold_q || done_found;
    req_ready  = free_found && !flush;
    alloc      = req_valid && req_ready;
    cache_re   = new_found && !flush;
    cache_addr = cache_re ? addr_q[new_idx] : '0;
    miss_addr  = addr_q[miss_idx];
    merge      = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (st_q[j] == ST_INFLIGHT && addr_q[j] == miss_addr) merge = 1'b1;
    end
    mem_re     = miss_found && !merge && !flush;
    mem_raddr  = mem_re ? miss_addr : '0;
    valid_out  = sel_valid;
    tag_out    = sel_valid ? tag_q[sel_idx] : '0;
    res_out    = sel_valid ? data_q[sel_idx] : '0;
    pop        = valid_out && res_ready;
    busy       = ~&free_vec;
    hold_d     = valid_out && !res_ready && !flush;
    hold_idx_d = sel_idx;
  end

  always_comb begin
    logic resp_hit;
    resp_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]   = st_q[i];
      tag_d[i]  = tag_q[i];
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      resp_hit  = mem_ready && (addr_q[i] == mem_addr_out);
      if (flush) begin
        st_d[i] = ST_FREE;
      end else begin
        case (st_q[i])
          ST_FREE: begin
            if (alloc && free_idx == IW'(i)) begin
              st_d[i]   = ST_NEW;
              tag_d[i]  = req_tag;
              addr_d[i] = req_addr;
            end
          end
          ST_NEW: begin
            if (new_idx == IW'(i)) st_d[i] = ST_LOOKUP;
          end
          ST_LOOKUP: begin
            if (cache_hit) begin
              st_d[i]   = ST_DONE;
              data_d[i] = cache_data;
            end else if (resp_hit) begin
              st_d[i]   = ST_DONE;
              data_d[i] = mem_data_out;
            end else begin
              st_d[i] = ST_MISS;
            end
          end
          ST_MISS: begin
            if (resp_hit) begin
              st_d[i]   = ST_DONE;
              data_d[i] = mem_data_out;
            end else if (miss_idx == IW'(i)) begin
              st_d[i] = ST_INFLIGHT;
            end
          end
          ST_INFLIGHT: begin
            if (resp_hit) begin
              st_d[i]   = ST_DONE;
              data_d[i] = mem_data_out;
            end
          end
          ST_DONE: begin
            if (pop && sel_idx == IW'(i)) st_d[i] = ST_FREE;
          end
          default: st_d[i] = ST_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_FREE;
        tag_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= st_d[i];
        tag_q[i]  <= tag_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_ld_queue.sv
// Directed bench for ld_queue: hit, miss, merge, out-of-order with CDB
// backpressure, flush and mid-miss reset.
module tb_ld_queue;

  logic        clk, rst_n, flush;
  logic        req_valid, req_ready;
  logic [5:0]  req_tag;
  logic [15:0] req_addr;
  logic        cache_re, cache_hit;
  logic [15:0] cache_addr, cache_data;
  logic        mem_re, mem_ready;
  logic [15:0] mem_raddr, mem_addr_out, mem_data_out;
  logic        valid_out, res_ready, busy;
  logic [5:0]  tag_out;
  logic [15:0] res_out;

  int          n_chk, n_bad, mem_cnt;
  logic        hit_mode;
  logic [15:0] hit_data;
  logic [5:0]  q_tag[$];
  logic [15:0] q_data[$];

  ld_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr), .req_ready(req_ready),
    .cache_re(cache_re), .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_data(cache_data),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .valid_out(valid_out), .tag_out(tag_out), .res_out(res_out), .res_ready(res_ready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge. Models the L1D
  // (hit/miss answered the cycle after cache_re) and logs mem_re and CDB pops.
  task automatic step();
    logic re_s;
    #1;
    re_s = cache_re;
    if (mem_re) mem_cnt++;
    if (valid_out && res_ready) begin
      q_tag.push_back(tag_out);
      q_data.push_back(res_out);
    end
    @(posedge clk);
    #1;
    cache_hit  = re_s && hit_mode;
    cache_data = (re_s && hit_mode) ? hit_data : 16'h0;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input logic [5:0] t, input logic [15:0] a);
    req_valid = 1'b1;
    req_tag   = t;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [15:0] a, input logic [15:0] d);
    mem_ready    = 1'b1;
    mem_addr_out = a;
    mem_data_out = d;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic chk_res(input string name, input int i, input logic [5:0] t, input logic [15:0] d);
    logic [5:0]  gt;
    logic [15:0] gd;
    gt = (i < q_tag.size()) ? q_tag[i] : 6'h3f;
    gd = (i < q_data.size()) ? q_data[i] : 16'hffff;
    chk({name, "_tag"}, 32'(gt), 32'(t));
    chk({name, "_data"}, 32'(gd), 32'(d));
  endtask

  task automatic clear_log();
    q_tag.delete();
    q_data.delete();
    mem_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_cache_re"}, 32'(cache_re), 0);
    chk({name, "_cache_addr"}, 32'(cache_addr), 0);
    chk({name, "_mem_re"}, 32'(mem_re), 0);
    chk({name, "_mem_raddr"}, 32'(mem_raddr), 0);
    chk({name, "_valid"}, 32'(valid_out), 0);
    chk({name, "_tag_out"}, 32'(tag_out), 0);
    chk({name, "_res_out"}, 32'(res_out), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0; mem_cnt = 0;
    rst_n = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_tag = '0; req_addr = '0;
    cache_hit = 1'b0; cache_data = '0;
    mem_ready = 1'b0; mem_addr_out = '0; mem_data_out = '0;
    res_ready = 1'b1;
    hit_mode = 1'b0; hit_data = '0;

    #3;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    @(negedge clk);

    // hit: valid_out two cycles after accept
    hit_mode = 1'b1; hit_data = 16'h1234;
    clear_log();
    issue(6'd3, 16'h0040);
    chk("hit_cache_re", 32'(cache_re), 1);
    chk("hit_cache_addr", 32'(cache_addr), 32'h0040);
    step();
    chk("hit_not_yet", 32'(valid_out), 0);
    step();
    chk("hit_valid", 32'(valid_out), 1);
    chk("hit_tag", 32'(tag_out), 3);
    chk("hit_data", 32'(res_out), 32'h1234);
    step();
    chk("hit_busy_after", 32'(busy), 0);
    chk("hit_no_mem", 32'(mem_cnt), 0);
    hit_mode = 1'b0;

    // miss
    clear_log();
    issue(6'd5, 16'h0100);
    step();
    step();
    chk("miss_mem_re", 32'(mem_re), 1);
    chk("miss_raddr", 32'(mem_raddr), 32'h0100);
    drain(4);
    chk("miss_wait_valid", 32'(valid_out), 0);
    respond(16'h0100, 16'hBEEF);
    chk("miss_valid", 32'(valid_out), 1);
    chk("miss_tag", 32'(tag_out), 5);
    chk("miss_data", 32'(res_out), 32'hBEEF);
    step();
    chk("miss_mem_cnt", 32'(mem_cnt), 1);
    chk("miss_busy_after", 32'(busy), 0);

    // merge: two loads to one address share one request
    clear_log();
    issue(6'd1, 16'h0200);
    issue(6'd2, 16'h0200);
    drain(4);
    respond(16'h0200, 16'hCAFE);
    drain(3);
    chk("merge_mem_cnt", 32'(mem_cnt), 1);
    chk("merge_cnt", 32'(q_tag.size()), 2);
    chk_res("merge0", 0, 6'd1, 16'hCAFE);
    chk_res("merge1", 1, 6'd2, 16'hCAFE);
    chk("merge_busy", 32'(busy), 0);

    // out-of-order responses with CDB stall
    clear_log();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(6'(10 + i), 16'(16'h0010 + i));
    req_valid = 1'b1; req_tag = 6'd20; req_addr = 16'h0050;
    #1;
    chk("ooo_full_ready", 32'(req_ready), 0);
    step();
    req_valid = 1'b0;
    drain(4);
    chk("ooo_mem_cnt", 32'(mem_cnt), 4);
    chk("ooo_busy", 32'(busy), 1);
    respond(16'h0013, 16'h5513);
    chk("ooo_first_valid", 32'(valid_out), 1);
    chk("ooo_first_tag", 32'(tag_out), 13);
    respond(16'h0012, 16'h5512);
    chk("ooo_stall_tag1", 32'(tag_out), 13);
    respond(16'h0011, 16'h5511);
    respond(16'h0010, 16'h5510);
    chk("ooo_stall_tag2", 32'(tag_out), 13);
    chk("ooo_stall_data", 32'(res_out), 32'h5513);
    res_ready = 1'b1;
    drain(5);
    chk("ooo_cnt", 32'(q_tag.size()), 4);
    chk_res("ooo0", 0, 6'd13, 16'h5513);
    chk_res("ooo1", 1, 6'd10, 16'h5510);
    chk_res("ooo2", 2, 6'd11, 16'h5511);
    chk_res("ooo3", 3, 6'd12, 16'h5512);
    chk("ooo_busy_after", 32'(busy), 0);

    // flush with two loads in flight
    clear_log();
    issue(6'd30, 16'h0300);
    issue(6'd31, 16'h0310);
    drain(4);
    chk("fl_mem_cnt", 32'(mem_cnt), 2);
    flush = 1'b1;
    req_valid = 1'b1; req_tag = 6'd32; req_addr = 16'h0320;
    #1;
    chk("fl_req_ready", 32'(req_ready), 0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_busy", 32'(busy), 0);
    respond(16'h0300, 16'h1111);
    respond(16'h0310, 16'h2222);
    drain(2);
    chk("fl_no_result", 32'(q_tag.size()), 0);
    chk("fl_busy_end", 32'(busy), 0);

    // asynchronous reset mid-miss
    clear_log();
    issue(6'd40, 16'h0400);
    step();
    step();
    chk("rm_mem_re", 32'(mem_re), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rm");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    respond(16'h0400, 16'h4444);
    drain(2);
    chk("rm_no_result", 32'(q_tag.size()), 0);
    chk("rm_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
